// File: rtl/gpio_pad_pkg.sv
// Shared types and constants for the sky130 gpiov2 pad sequencer family.
package gpio_pad_pkg;

  // Sequencer phases: power-up ramp, steady state, hold-protected config
  // apply, and the frozen (hold override) sleep state.
  typedef enum logic [2:0] {
    PWR_WAIT,
    EN_H,
    EN_INP,
    ACTIVE,
    HOLD_SETUP,
    APPLY,
    HOLD_REL,
    SLEEP
  } seq_state_e;

  // Everything the pad latches under HLD_H_N.
  typedef struct packed {
    logic [2:0] dm;
    logic       slow;
    logic       vtrip_sel;
    logic       ib_mode_sel;
    logic       inp_dis;
    logic       analog_en;
    logic       analog_sel;
    logic       analog_pol;
  } pad_cfg_t;

  // Safe pad state: input-only drive mode, input buffer disabled, analog off.
  localparam pad_cfg_t PAD_CFG_RESET = '{
    dm:          3'b001,
    slow:        1'b0,
    vtrip_sel:   1'b0,
    ib_mode_sel: 1'b0,
    inp_dis:     1'b1,
    analog_en:   1'b0,
    analog_sel:  1'b0,
    analog_pol:  1'b0
  };

endpackage

// File: rtl/sky130_gpio_pad_sequencer.sv
// Power-up, config-apply and sleep sequencer for one sky130 gpiov2 pad.
// Every pad-facing output comes straight from a flop; cfg_ready is the only
// output that depends combinationally on an input (sleep_req), so that a
// sleep request can veto a config handshake in the same cycle.
module sky130_gpio_pad_sequencer
  import gpio_pad_pkg::*;
#(
  parameter int unsigned PWRUP_CYCLES = 64,
  parameter int unsigned STEP_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES  = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [2:0] cfg_dm,
  input  logic       cfg_slow,
  input  logic       cfg_vtrip_sel,
  input  logic       cfg_ib_mode_sel,
  input  logic       cfg_inp_dis,
  input  logic       cfg_analog_en,
  input  logic       cfg_analog_sel,
  input  logic       cfg_analog_pol,
  input  logic       sleep_req,
  output logic       sleep_ack,
  output logic       pad_ready,
  output logic [2:0] pad_dm,
  output logic       pad_slow,
  output logic       pad_vtrip_sel,
  output logic       pad_ib_mode_sel,
  output logic       pad_inp_dis,
  output logic       pad_analog_en,
  output logic       pad_analog_sel,
  output logic       pad_analog_pol,
  output logic       pad_hld_h_n,
  output logic       pad_hld_ovr,
  output logic       pad_enable_h,
  output logic       pad_enable_inp_h,
  output logic       pad_enable_vdda_h,
  output logic       pad_enable_vswitch_h,
  output logic       pad_enable_vddio
);

  // Terminal counts: the counter restarts at zero on every state entry, so
  // a wait of N cycles ends when it reads N-1.
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waking_q, waking_d;     // SLEEP sub-phase: hold release
  pad_cfg_t         shadow_q, shadow_d;     // accepted, not yet applied
  pad_cfg_t         cfg_q, cfg_d;           // what the pad currently sees
  logic             hld_h_n_q, hld_h_n_d;
  logic             hld_ovr_q, hld_ovr_d;
  logic             rail_en_q, rail_en_d;   // h / vddio / vdda_h / vswitch_h
  logic             en_inp_q, en_inp_d;
  logic             sleep_ack_q, sleep_ack_d;
  logic             ready_q, ready_d;
  pad_cfg_t         cfg_in;

  assign cfg_in = '{
    dm:          cfg_dm,
    slow:        cfg_slow,
    vtrip_sel:   cfg_vtrip_sel,
    ib_mode_sel: cfg_ib_mode_sel,
    inp_dis:     cfg_inp_dis,
    analog_en:   cfg_analog_en,
    analog_sel:  cfg_analog_sel,
    analog_pol:  cfg_analog_pol
  };

  // Sleep has priority over a pending config, so ready drops the moment
  // sleep_req is seen in ACTIVE.
  assign cfg_ready = (state_q == ACTIVE) && !sleep_req;

  // Next-state and next-output decode for the whole sequencer.
  always_comb begin
    // NOTE: every *_d gets a default before the case, so no path through
    // the decode leaves a variable unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    waking_d    = waking_q;
    shadow_d    = shadow_q;
    cfg_d       = cfg_q;
    hld_h_n_d   = hld_h_n_q;
    hld_ovr_d   = hld_ovr_q;
    rail_en_d   = rail_en_q;
    en_inp_d    = en_inp_q;
    sleep_ack_d = sleep_ack_q;
    ready_d     = ready_q;

    unique case (state_q)
      PWR_WAIT: begin
        if (cnt_q == PWRUP_LAST) begin
          rail_en_d = 1'b1;
          cnt_d     = '0;
          state_d   = EN_H;
        end
      end

      EN_H: begin
        if (cnt_q == STEP_LAST) begin
          en_inp_d = 1'b1;
          cnt_d    = '0;
          state_d  = EN_INP;
        end
      end

      EN_INP: begin
        if (cnt_q == STEP_LAST) begin
          hld_h_n_d = 1'b1;
          ready_d   = 1'b1;   // stays set until the next reset
          cnt_d     = '0;
          state_d   = ACTIVE;
        end
      end

      ACTIVE: begin
        cnt_d = cnt_q;        // idle here; avoid a free-running wrap
        if (sleep_req) begin
          hld_h_n_d = 1'b0;
          hld_ovr_d = 1'b1;
          waking_d  = 1'b0;
          cnt_d     = '0;
          state_d   = SLEEP;
        end else if (cfg_valid) begin
          shadow_d  = cfg_in;
          hld_h_n_d = 1'b0;
          cnt_d     = '0;
          state_d   = HOLD_SETUP;
        end
      end

      HOLD_SETUP: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = APPLY;
        end
      end

      APPLY: begin
        cfg_d   = shadow_q;
        cnt_d   = '0;
        state_d = HOLD_REL;
      end

      HOLD_REL: begin
        if (cnt_q == HOLD_LAST) begin
          hld_h_n_d = 1'b1;
          cnt_d     = '0;
          state_d   = ACTIVE;
        end
      end

      SLEEP: begin
        if (waking_q) begin
          // Override already dropped; keep the latch closed a little longer.
          if (cnt_q == HOLD_LAST) begin
            hld_h_n_d = 1'b1;
            waking_d  = 1'b0;
            cnt_d     = '0;
            state_d   = ACTIVE;
          end
        end else if (!sleep_req) begin
          sleep_ack_d = 1'b0;
          hld_ovr_d   = 1'b0;
          waking_d    = 1'b1;
          cnt_d       = '0;
        end else if (cnt_q == HOLD_LAST) begin
          sleep_ack_d = 1'b1;
          cnt_d       = cnt_q;  // saturate while frozen
        end
      end

      default: begin
        state_d = PWR_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= '0;
      waking_q    <= 1'b0;
      // NOTE: the shadow is reset along with everything else so a config
      // captured before reset can never reach the pad afterwards.
      shadow_q    <= PAD_CFG_RESET;
      cfg_q       <= PAD_CFG_RESET;
      hld_h_n_q   <= 1'b0;
      hld_ovr_q   <= 1'b0;
      rail_en_q   <= 1'b0;
      en_inp_q    <= 1'b0;
      sleep_ack_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      waking_q    <= waking_d;
      shadow_q    <= shadow_d;
      cfg_q       <= cfg_d;
      hld_h_n_q   <= hld_h_n_d;
      hld_ovr_q   <= hld_ovr_d;
      rail_en_q   <= rail_en_d;
      en_inp_q    <= en_inp_d;
      sleep_ack_q <= sleep_ack_d;
      ready_q     <= ready_d;
    end
  end

  assign sleep_ack            = sleep_ack_q;
  assign pad_ready            = ready_q;
  assign pad_dm               = cfg_q.dm;
  assign pad_slow             = cfg_q.slow;
  assign pad_vtrip_sel        = cfg_q.vtrip_sel;
  assign pad_ib_mode_sel      = cfg_q.ib_mode_sel;
  assign pad_inp_dis          = cfg_q.inp_dis;
  assign pad_analog_en        = cfg_q.analog_en;
  assign pad_analog_sel       = cfg_q.analog_sel;
  assign pad_analog_pol       = cfg_q.analog_pol;
  assign pad_hld_h_n          = hld_h_n_q;
  assign pad_hld_ovr          = hld_ovr_q;
  assign pad_enable_h         = rail_en_q;
  assign pad_enable_vddio     = rail_en_q;
  assign pad_enable_vdda_h    = rail_en_q;
  assign pad_enable_vswitch_h = rail_en_q;
  assign pad_enable_inp_h     = en_inp_q;

endmodule

// File: tb/tb_sky130_gpio_pad_sequencer.sv
// Self-checking bench for sky130_gpio_pad_sequencer. The reference model
// is a timeline: it records at which clock edge each milestone happens
// (reset release, config accept, sleep entry/exit) and derives every
// expected output from those timestamps.
module tb_sky130_gpio_pad_sequencer;

  localparam int P   = 64;
  localparam int S   = 4;
  localparam int H   = 2;
  localparam int INF = 32'h3fff_ffff;
  localparam logic [9:0] CFG_SAFE = 10'b001_0_0_0_1_0_0_0;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_dm = '0;
  logic       cfg_slow = 1'b0, cfg_vtrip_sel = 1'b0, cfg_ib_mode_sel = 1'b0;
  logic       cfg_inp_dis = 1'b0, cfg_analog_en = 1'b0, cfg_analog_sel = 1'b0;
  logic       cfg_analog_pol = 1'b0;
  logic       sleep_req = 1'b0;
  logic       sleep_ack, pad_ready;
  logic [2:0] pad_dm;
  logic       pad_slow, pad_vtrip_sel, pad_ib_mode_sel, pad_inp_dis;
  logic       pad_analog_en, pad_analog_sel, pad_analog_pol;
  logic       pad_hld_h_n, pad_hld_ovr;
  logic       pad_enable_h, pad_enable_inp_h, pad_enable_vdda_h;
  logic       pad_enable_vswitch_h, pad_enable_vddio;

  always #5 clock = ~clock;

  sky130_gpio_pad_sequencer #(
    .PWRUP_CYCLES(P), .STEP_CYCLES(S), .HOLD_CYCLES(H), .CNT_W(8)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_dm(cfg_dm), .cfg_slow(cfg_slow), .cfg_vtrip_sel(cfg_vtrip_sel),
    .cfg_ib_mode_sel(cfg_ib_mode_sel), .cfg_inp_dis(cfg_inp_dis),
    .cfg_analog_en(cfg_analog_en), .cfg_analog_sel(cfg_analog_sel),
    .cfg_analog_pol(cfg_analog_pol),
    .sleep_req(sleep_req), .sleep_ack(sleep_ack), .pad_ready(pad_ready),
    .pad_dm(pad_dm), .pad_slow(pad_slow), .pad_vtrip_sel(pad_vtrip_sel),
    .pad_ib_mode_sel(pad_ib_mode_sel), .pad_inp_dis(pad_inp_dis),
    .pad_analog_en(pad_analog_en), .pad_analog_sel(pad_analog_sel),
    .pad_analog_pol(pad_analog_pol),
    .pad_hld_h_n(pad_hld_h_n), .pad_hld_ovr(pad_hld_ovr),
    .pad_enable_h(pad_enable_h), .pad_enable_inp_h(pad_enable_inp_h),
    .pad_enable_vdda_h(pad_enable_vdda_h),
    .pad_enable_vswitch_h(pad_enable_vswitch_h),
    .pad_enable_vddio(pad_enable_vddio)
  );

  wire [9:0] pad_cfg_obs = {pad_dm, pad_slow, pad_vtrip_sel, pad_ib_mode_sel,
                            pad_inp_dis, pad_analog_en, pad_analog_sel,
                            pad_analog_pol};
  wire [9:0] cfg_in_vec  = {cfg_dm, cfg_slow, cfg_vtrip_sel, cfg_ib_mode_sel,
                            cfg_inp_dis, cfg_analog_en, cfg_analog_sel,
                            cfg_analog_pol};
  wire [4:0] enables_obs = {pad_enable_h, pad_enable_inp_h, pad_enable_vdda_h,
                            pad_enable_vswitch_h, pad_enable_vddio};

  int n_tests = 0;
  int n_fail  = 0;

  // Timeline model state (edge indices).
  int         edge_n      = 0;
  int         rst_edge    = 0;
  int         act_from    = INF;  // edge at which the pad last became ACTIVE
  int         sleep_entry = 0;
  int         apply_at    = -1;
  bit         m_valid     = 1'b0;
  bit         sleeping    = 1'b0;
  bit         waking      = 1'b0;
  bit         m_ack       = 1'b0;
  logic [9:0] m_cfg       = CFG_SAFE;
  logic [9:0] m_pending   = CFG_SAFE;
  int         n_accept    = 0;
  int         obs_hs      = 0;
  logic [9:0] prev_cfg    = CFG_SAFE;
  logic       prev_hld    = 1'b0;
  bit         was_rst     = 1'b1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)",
               tag, got, exp, edge_n);
    end
  endtask

  function automatic bit next_active();
    return m_valid && !sleeping && (edge_n + 1 > act_from);
  endfunction

  // Advance the timeline by one clock edge using the inputs seen at it.
  task automatic model_edge();
    edge_n++;
    if (!reset_n) begin
      m_valid  = 1'b1;
      rst_edge = edge_n;
      act_from = edge_n + P + 2 * S;
      sleeping = 1'b0;
      waking   = 1'b0;
      m_ack    = 1'b0;
      m_cfg    = CFG_SAFE;
      apply_at = -1;
    end else if (m_valid) begin
      if (edge_n == apply_at) m_cfg = m_pending;
      if (sleeping && !waking) begin
        if (!sleep_req) begin
          waking   = 1'b1;
          m_ack    = 1'b0;
          act_from = edge_n + H;
        end else if (edge_n - sleep_entry >= H) begin
          m_ack = 1'b1;
        end
      end else if (waking) begin
        if (edge_n == act_from) begin
          sleeping = 1'b0;
          waking   = 1'b0;
        end
      end else if (edge_n > act_from) begin
        if (sleep_req) begin
          sleeping    = 1'b1;
          sleep_entry = edge_n;
          act_from    = INF;
        end else if (cfg_valid) begin
          m_pending = cfg_in_vec;
          apply_at  = edge_n + H + 1;
          act_from  = edge_n + 2 * H + 1;
          n_accept++;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    if (!m_valid) return;
    check("pad_cfg",   pad_cfg_obs, m_cfg);
    check("hld_h_n",   pad_hld_h_n, edge_n >= act_from);
    check("hld_ovr",   pad_hld_ovr, sleeping && !waking);
    check("sleep_ack", sleep_ack, m_ack);
    check("pad_ready", pad_ready, edge_n >= rst_edge + P + 2 * S);
    check("enables", enables_obs,
          {edge_n >= rst_edge + P, edge_n >= rst_edge + P + S,
           edge_n >= rst_edge + P, edge_n >= rst_edge + P,
           edge_n >= rst_edge + P});
    if (!was_rst && pad_cfg_obs !== prev_cfg)
      check("cfg_changed_while_open", {prev_hld, pad_hld_h_n}, 2'b00);
    prev_cfg = pad_cfg_obs;
    prev_hld = pad_hld_h_n;
  endtask

  // One clock: check the handshake side mid-cycle, then the edge results.
  task automatic step();
    @(negedge clock);
    if (m_valid) begin
      check("cfg_ready", cfg_ready, next_active() && !sleep_req);
      if (cfg_valid && cfg_ready) obs_hs++;
    end
    @(posedge clock);
    was_rst = !reset_n;
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic set_cfg(input logic [9:0] v);
    {cfg_dm, cfg_slow, cfg_vtrip_sel, cfg_ib_mode_sel, cfg_inp_dis,
     cfg_analog_en, cfg_analog_sel, cfg_analog_pol} = v;
  endtask

  task automatic wait_active(input int budget);
    bit ok = 1'b0;
    cfg_valid = 1'b0;
    sleep_req = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (next_active()) ok = 1'b1;
      else step();
    end
    if (!ok) ok = next_active();
    check("wait_active_in_budget", ok, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    repeat (3) step();
    reset_n = 1'b1;

    // Power-up with noisy cfg_valid / sleep_req, which must be ignored.
    for (int i = 0; i < 60; i++) begin
      cfg_valid = 1'($urandom);
      sleep_req = 1'($urandom);
      set_cfg(10'($urandom));
      step();
    end
    wait_active(40);
    check("ready_after_powerup", pad_ready, 1'b1);

    // Single config write.
    h0 = obs_hs;
    set_cfg(10'b110_1_0_0_0_0_0_0);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    repeat (8) step();
    check("write_handshakes", obs_hs - h0, 1);
    check("write_dm", pad_dm, 3'b110);
    check("write_slow", pad_slow, 1'b1);

    // Back-to-back: valid held across two values.
    h0 = obs_hs;
    cfg_valid = 1'b1;
    set_cfg(10'b011_0_1_0_0_1_0_1);
    step();
    set_cfg(10'b101_0_0_1_1_0_1_0);
    for (int i = 0; i < 20 && n_accept < 3; i++) step();
    cfg_valid = 1'b0;
    repeat (8) step();
    check("b2b_handshakes", obs_hs - h0, 2);
    check("b2b_final_cfg", pad_cfg_obs, 10'b101_0_0_1_1_0_1_0);

    // Sleep and config offered together: sleep wins.
    wait_active(20);
    h0 = obs_hs;
    sleep_req = 1'b1;
    cfg_valid = 1'b1;
    set_cfg(10'b010_1_1_1_0_1_1_1);
    repeat (5) step();
    cfg_valid = 1'b0;
    check("sleep_no_handshake", obs_hs - h0, 0);
    check("sleep_frozen", {sleep_ack, pad_hld_ovr, pad_hld_h_n}, 3'b110);
    check("sleep_cfg_kept", pad_cfg_obs, 10'b101_0_0_1_1_0_1_0);
    sleep_req = 1'b0;
    repeat (4) step();
    check("sleep_released", {sleep_ack, pad_hld_ovr, pad_hld_h_n}, 3'b001);

    // Reset asserted for one cycle while in APPLY.
    wait_active(20);
    set_cfg(10'b111_1_1_1_0_1_1_1);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 10 && edge_n != apply_at - 1; i++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("rst_apply_cfg", pad_cfg_obs, CFG_SAFE);
    check("rst_apply_enables", enables_obs, 5'b0);
    check("rst_apply_hold", {pad_hld_h_n, pad_hld_ovr, pad_ready}, 3'b000);
    wait_active(100);
    check("rst_shadow_dropped", pad_cfg_obs, CFG_SAFE);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) sleep_req = ~sleep_req;
      cfg_valid = 1'($urandom);
      set_cfg(10'($urandom));
      reset_n = ($urandom_range(0, 999) != 0);
      step();
    end
    reset_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sky130_gpio_pad_sequencer.md
Name: sky130_gpio_pad_sequencer

Overview:
Controller for one sky130 gpiov2 pad. Sequences the pad power-up enables (ENABLE_H, ENABLE_INP_H, ENABLE_VDDA_H, ENABLE_VSWITCH_H, ENABLE_VDDIO). Applies mode/config changes glitch-free under the pad hold latch (HLD_H_N), and supports a sleep/hold-override mode. It sits between the chip's IO config registers and the pad wrapper; the functional OUT/OE_N/IN paths do not pass through it.

Parameters:
PWRUP_CYCLES, 64, cycles after reset release before ENABLE_H rises
STEP_CYCLES, 4, cycles between successive enable steps
HOLD_CYCLES, 2, hold-setup and hold-release cycles around a config apply
CNT_W, 8, counter width; must satisfy 2^CNT_W > max(PWRUP_CYCLES, STEP_CYCLES, HOLD_CYCLES)

Ports:
clock  in  1  single clock
reset_n  in  1  synchronous, active-low reset
cfg_valid  in  1  new config offered
cfg_ready  out  1  config accepted this cycle when valid&ready
cfg_dm  in  3  drive mode
cfg_slow, cfg_vtrip_sel, cfg_ib_mode_sel, cfg_inp_dis  in  1 each  pad config bits
cfg_analog_en, cfg_analog_sel, cfg_analog_pol  in  1 each  analog mux config
sleep_req  in  1  level; request pad freeze
sleep_ack  out  1  pad frozen under hold override
pad_ready  out  1  power-up complete, state ACTIVE
pad_dm  out  3  to DM
pad_slow, pad_vtrip_sel, pad_ib_mode_sel, pad_inp_dis  out  1 each  to pad
pad_analog_en, pad_analog_sel, pad_analog_pol  out  1 each  to pad
pad_hld_h_n, pad_hld_ovr  out  1 each  hold controls
pad_enable_h, pad_enable_inp_h, pad_enable_vdda_h, pad_enable_vswitch_h, pad_enable_vddio  out  1 each  enables

Behaviour:
- Reset (reset_n=0 sampled at a clock edge): state=PWR_WAIT, counter=0.
  - Outputs: pad_dm=3'b001, pad_inp_dis=1, all other config bits 0.
  - pad_hld_h_n=0, pad_hld_ovr=0, all enables 0.
  - cfg_ready=0, sleep_ack=0, pad_ready=0.
- All outputs are registered; no combinational path from inputs to pad_* outputs.
- States: PWR_WAIT, EN_H, EN_INP, ACTIVE, HOLD_SETUP, APPLY, HOLD_REL, SLEEP.
- PWR_WAIT:
  - Counts PWRUP_CYCLES.
  - Then sets pad_enable_h=1, pad_enable_vddio=1, pad_enable_vdda_h=1, pad_enable_vswitch_h=1, and goes to EN_H.
- EN_H:
  - Waits STEP_CYCLES, then sets pad_enable_inp_h=1 and goes to EN_INP.
- EN_INP:
  - Waits STEP_CYCLES, then sets pad_hld_h_n=1 and goes to ACTIVE.
  - pad_ready=1 from the first ACTIVE cycle.
- ACTIVE:
  - cfg_ready=1 only here and only when sleep_req=0.
  - Handshake: cfg_valid&cfg_ready captures all cfg_* into a shadow register, drives pad_hld_h_n=0 next cycle, and goes to HOLD_SETUP.
  - cfg_valid held without ready is not accepted; the value may change freely while not ready.
- HOLD_SETUP: waits HOLD_CYCLES with hold asserted, then goes to APPLY.
- APPLY: one cycle; pad_* config outputs load from the shadow register; goes to HOLD_REL.
- HOLD_REL: waits HOLD_CYCLES, then sets pad_hld_h_n=1 and returns to ACTIVE.
  - Config pins never change while pad_hld_h_n=1.
- Sleep entry, from ACTIVE with sleep_req=1:
  - pad_hld_h_n=0 and pad_hld_ovr=1 the same edge; goes to SLEEP.
  - sleep_ack=1 after HOLD_CYCLES in SLEEP.
- Sleep exit, sleep_req=0 in SLEEP:
  - sleep_ack=0 immediately (registered), pad_hld_ovr=0.
  - Waits HOLD_CYCLES, then pad_hld_h_n=1 and goes to ACTIVE.
- Simultaneous cfg_valid and sleep_req in ACTIVE: sleep wins; cfg_ready=0 that cycle.
- sleep_req rising during HOLD_SETUP/APPLY/HOLD_REL: the config sequence completes first, then ACTIVE enters SLEEP.
- sleep_req during power-up: ignored until ACTIVE.
- Reset mid-operation (any state): immediate return to reset values and a full power-up replay.
  - A shadow config not yet applied is discarded.
- Counter: zero on every state entry; compares against (param-1); no wrap in normal operation.

Decomposition:
- Shared package gpio_pad_pkg:
  - state enum.
  - pad_cfg_t struct (dm, slow, vtrip_sel, ib_mode_sel, inp_dis, analog_en/sel/pol).
  - constant PAD_CFG_RESET (dm=3'b001, inp_dis=1, rest 0).
- No sub-module needed. Optionally factor out a generic down-counter sky130_seq_timer (load/done) shared with future multi-pad arbiters.

Test Plan:
- Power-up: release reset, PWRUP_CYCLES=64, STEP_CYCLES=4.
  - enable_h rises at cycle 64, enable_inp_h at 68, hld_h_n at 72, pad_ready at 72.
  - cfg_ready=0 throughout.
- Config write: in ACTIVE, drive cfg_valid with dm=3'b110, slow=1.
  - hld_h_n falls 1 cycle after handshake.
  - pad_dm=3'b110 appears 2+HOLD_CYCLES cycles later.
  - hld_h_n rises HOLD_CYCLES after that.
  - The bench asserts pad_dm never changes while hld_h_n=1.
- Back-to-back: cfg_valid held high with two values.
  - Second accepted only after return to ACTIVE.
  - cfg_ready=0 during HOLD_SETUP/APPLY/HOLD_REL.
- Sleep: sleep_req=1 and cfg_valid=1 the same cycle.
  - No config accepted; hld_ovr=1, hld_h_n=0, sleep_ack=1 after 2 cycles.
  - Release: sleep_ack=0, hld_h_n=1 after 2 cycles.
- Reset mid-APPLY: assert reset_n=0 for 1 cycle during APPLY.
  - All outputs at reset values next cycle (pad_dm=3'b001, inp_dis=1, enables 0).
  - Full 72-cycle power-up repeats.
